// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream and instruction-memory write bus for imem_loader
interface imem_loader_if #(
   parameter int XLEN = 32,
   parameter int ILEN = 32
);
   logic [7:0]      byte_data;
   logic            byte_valid;
   logic            byte_ready;
   logic [XLEN-1:0] mem_addr;
   logic [ILEN-1:0] mem_wdata;
   logic            mem_write_en;

   // master: the loader (accepts bytes, drives memory writes)
   modport master (
      input  byte_data, byte_valid,
      output byte_ready, mem_addr, mem_wdata, mem_write_en
   );

   // slave: byte source and instruction memory side
   modport slave (
      output byte_data, byte_valid,
      input  byte_ready, mem_addr, mem_wdata, mem_write_en
   );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - packs a length-prefixed LE byte stream into 32-bit instruction memory writes
module imem_loader #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned ILEN      = 32,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned MEM_BYTES = 1024
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          restart,
   imem_loader_if.master bus,
   output logic          core_hold,
   output logic          load_done,
   output logic          load_error
);
   typedef enum logic [2:0] {
      S_HEADER,
      S_PAYLOAD,
      S_WRITE,
      S_DONE,
      S_ERROR
   } state_e;

   state_e          state_q, state_d;
   logic            byte_ready_q, byte_ready_d;
   logic [1:0]      cnt_q, cnt_d;
   logic [31:0]     len_q, len_d;
   logic [29:0]     words_q, words_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [ILEN-1:0] wdata_q, wdata_d;
   logic            accept;
   logic [31:0]     hdr_len;

   assign accept  = bus.byte_valid && byte_ready_q;
   // full LEN as it will be once the 4th header byte lands
   assign hdr_len = {bus.byte_data, len_q[23:0]};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= S_HEADER;
         byte_ready_q <= 1'b0;
         cnt_q        <= '0;
         len_q        <= '0;
         words_q      <= '0;
         addr_q       <= XLEN'(BASE_ADDR);
         wdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         byte_ready_q <= byte_ready_d;
         cnt_q        <= cnt_d;
         len_q        <= len_d;
         words_q      <= words_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      words_d = words_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         S_HEADER: begin
            if (accept) begin
               len_d[{cnt_q, 3'b000} +: 8] = bus.byte_data;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  words_d = '0;
                  if (hdr_len[1:0] != 2'b00 || hdr_len > 32'(MEM_BYTES)) begin
                     state_d = S_ERROR;
                  end else if (hdr_len == 32'd0) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_PAYLOAD;
                  end
               end
            end
         end
         S_PAYLOAD: begin
            if (accept) begin
               wdata_d[{cnt_q, 3'b000} +: 8] = bus.byte_data;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            addr_d  = addr_q + XLEN'(4);
            words_d = words_q + 30'd1;
            state_d = (words_d == len_q[31:2]) ? S_DONE : S_PAYLOAD;
         end
         S_DONE, S_ERROR: begin
            if (restart) begin
               state_d = S_HEADER;
               addr_d  = XLEN'(BASE_ADDR);
               cnt_d   = '0;
            end
         end
         default: state_d = S_HEADER;
      endcase
      // registered from next state: no combinational path from byte_valid
      byte_ready_d = (state_d == S_HEADER) || (state_d == S_PAYLOAD);
   end

   assign bus.byte_ready   = byte_ready_q;
   assign bus.mem_addr     = addr_q;
   assign bus.mem_wdata    = wdata_q;
   assign bus.mem_write_en = (state_q == S_WRITE);
   assign core_hold        = (state_q != S_DONE);
   assign load_done        = (state_q == S_DONE);
   assign load_error       = (state_q == S_ERROR);
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader against a byte-count model
module tb_imem_loader;
   logic clock   = 1'b0;
   logic reset   = 1'b0;
   logic restart = 1'b0;
   logic core_hold, load_done, load_error;

   imem_loader_if #(.XLEN(32), .ILEN(32)) bus ();

   imem_loader #(.XLEN(32), .ILEN(32), .BASE_ADDR(0), .MEM_BYTES(1024)) dut (
      .clock     (clock),
      .reset     (reset),
      .restart   (restart),
      .bus       (bus),
      .core_hold (core_hold),
      .load_done (load_done),
      .load_error(load_error)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clock) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // observed writes
   logic [31:0] wl_addr[$];
   logic [31:0] wl_data[$];
   int          wl_cyc[$];

   // model: the image is the byte sequence accepted since load start
   logic [7:0]  m_bytes[$];
   logic [31:0] m_len, m_addr, m_data;
   int          m_words, m_n;
   bit          m_we, m_done, m_err;

   task automatic model_clear();
      m_bytes.delete();
      m_len = 0; m_words = 0; m_we = 0; m_done = 0; m_err = 0;
   endtask

   initial model_clear();

   always @(negedge clock) begin
      if (reset) begin
         model_clear();
      end else begin
         if (bus.mem_write_en) begin
            wl_addr.push_back(bus.mem_addr);
            wl_data.push_back(bus.mem_wdata);
            wl_cyc.push_back(cyc);
         end
         chk("write_en", {31'd0, bus.mem_write_en}, {31'd0, m_we});
         if (m_we && bus.mem_write_en) begin
            chk("write_addr", bus.mem_addr, m_addr);
            chk("write_data", bus.mem_wdata, m_data);
         end
         chk("load_done", {31'd0, load_done}, {31'd0, m_done});
         chk("load_error", {31'd0, load_error}, {31'd0, m_err});
         chk("core_hold", {31'd0, core_hold}, {31'd0, !m_done});
         if (m_we || m_done || m_err) chk("ready_low", {31'd0, bus.byte_ready}, 32'd0);
         // advance the model across the coming edge
         if ((m_done || m_err) && restart) begin
            model_clear();
         end else if (m_we) begin
            m_we = 0;
            m_words++;
            if (m_words == int'(m_len / 4)) m_done = 1;
         end else if (!m_done && !m_err && bus.byte_valid && bus.byte_ready) begin
            m_bytes.push_back(bus.byte_data);
            m_n = m_bytes.size();
            if (m_n == 4) begin
               m_len = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
               if (m_len % 4 != 0 || m_len > 1024) m_err = 1;
               else if (m_len == 0) m_done = 1;
            end else if (m_n > 4 && (m_n - 4) % 4 == 0) begin
               m_we   = 1;
               m_addr = 32'(m_n - 8);
               m_data = {m_bytes[m_n-1], m_bytes[m_n-2], m_bytes[m_n-3], m_bytes[m_n-4]};
            end
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit acc;
      bit ok;
      if (gap > 0) begin
         bus.byte_valid = 1'b0;
         repeat (gap) step();
      end
      bus.byte_data  = b;
      bus.byte_valid = 1'b1;
      ok = 0;
      for (int t = 0; t < 40 && !ok; t++) begin
         @(negedge clock);
         acc = bus.byte_ready;
         step();
         ok = acc;
      end
      chk("byte_accepted", {31'd0, ok}, 32'd1);
   endtask

   task automatic send4(input logic [31:0] w, input int gap);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
   endtask

   task automatic idle();
      bus.byte_valid = 1'b0;
   endtask

   task automatic wait_done();
      for (int t = 0; t < 300 && !load_done; t++) step();
      chk("done_reached", {31'd0, load_done}, 32'd1);
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      step();
      restart = 1'b0;
   endtask

   task automatic chk_write(input int idx, input logic [31:0] addr, input logic [31:0] data);
      if (idx < wl_addr.size()) begin
         chk("log_addr", wl_addr[idx], addr);
         chk("log_data", wl_data[idx], data);
      end else begin
         chk("log_missing", wl_addr.size(), 32'(idx + 1));
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_ready", {31'd0, bus.byte_ready}, 32'd0);
      chk("rst_we", {31'd0, bus.mem_write_en}, 32'd0);
      chk("rst_hold", {31'd0, core_hold}, 32'd1);
      chk("rst_done", {31'd0, load_done}, 32'd0);
      chk("rst_error", {31'd0, load_error}, 32'd0);
      chk("rst_addr", bus.mem_addr, 32'd0);
      chk("rst_wdata", bus.mem_wdata, 32'd0);
   endtask

   int base;

   initial begin
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      #1 reset = 1'b1;
      #1 chk_reset_outputs();
      repeat (3) @(posedge clock);
      #2 reset = 1'b0;
      chk("ready_before_first_edge", {31'd0, bus.byte_ready}, 32'd0);
      step();
      chk("ready_after_first_edge", {31'd0, bus.byte_ready}, 32'd1);

      // normal load, valid held high throughout
      base = wl_addr.size();
      send4(32'd8, 0);
      send4(32'h0000_0013, 0);
      send4(32'h0010_0093, 0);
      idle();
      chk("we_after_last_byte", {31'd0, bus.mem_write_en}, 32'd1);
      step();
      chk("done_after_write", {31'd0, load_done}, 32'd1);
      chk("hold_after_write", {31'd0, core_hold}, 32'd0);
      chk("normal_nwrites", wl_addr.size() - base, 32'd2);
      chk_write(base, 32'h0, 32'h0000_0013);
      chk_write(base + 1, 32'h4, 32'h0010_0093);
      if (wl_cyc.size() >= base + 2) chk("write_spacing", 32'(wl_cyc[base+1] - wl_cyc[base]), 32'd5);

      // restart after done
      pulse_restart();
      chk("restart_hold", {31'd0, core_hold}, 32'd1);
      chk("restart_done_clr", {31'd0, load_done}, 32'd0);
      chk("restart_addr", bus.mem_addr, 32'd0);
      base = wl_addr.size();
      send4(32'd4, 0);
      send4(32'h0403_0201, 0);
      idle();
      wait_done();
      chk("restart_nwrites", wl_addr.size() - base, 32'd1);
      chk_write(base, 32'h0, 32'h0403_0201);

      // same image with 3-cycle gaps between bytes
      pulse_restart();
      base = wl_addr.size();
      send4(32'd8, 3);
      send4(32'h0000_0013, 3);
      send4(32'h0010_0093, 3);
      idle();
      wait_done();
      chk("gap_nwrites", wl_addr.size() - base, 32'd2);
      chk_write(base, 32'h0, 32'h0000_0013);
      chk_write(base + 1, 32'h4, 32'h0010_0093);

      // zero length
      pulse_restart();
      base = wl_addr.size();
      send4(32'd0, 0);
      idle();
      chk("zero_done", {31'd0, load_done}, 32'd1);
      chk("zero_hold", {31'd0, core_hold}, 32'd0);
      bus.byte_data  = 8'hAA;
      bus.byte_valid = 1'b1;
      repeat (4) begin
         @(negedge clock);
         chk("zero_no_ack", {31'd0, bus.byte_ready}, 32'd0);
         step();
      end
      idle();
      chk("zero_nwrites", wl_addr.size() - base, 32'd0);

      // rejected headers
      pulse_restart();
      send4(32'd6, 0);
      idle();
      chk("len6_error", {31'd0, load_error}, 32'd1);
      chk("len6_hold", {31'd0, core_hold}, 32'd1);
      chk("len6_ready", {31'd0, bus.byte_ready}, 32'd0);
      pulse_restart();
      chk("len6_cleared", {31'd0, load_error}, 32'd0);
      chk("len6_rearmed", {31'd0, bus.byte_ready}, 32'd1);
      send4(32'h0000_0404, 0);
      idle();
      chk("len404_error", {31'd0, load_error}, 32'd1);
      pulse_restart();
      chk("len404_cleared", {31'd0, load_error}, 32'd0);

      // LEN equal to capacity is legal; reset two bytes into the second word
      base = wl_addr.size();
      send4(32'h0000_0400, 0);
      chk("len400_no_error", {31'd0, load_error}, 32'd0);
      chk("len400_ready", {31'd0, bus.byte_ready}, 32'd1);
      send4(32'hCAFE_F00D, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      idle();
      chk_write(base, 32'h0, 32'hCAFE_F00D);
      #1 reset = 1'b1;
      #1 chk_reset_outputs();
      step();
      step();
      reset = 1'b0;
      base = wl_addr.size();
      send4(32'd4, 0);
      send4(32'hDEAD_BEEF, 0);
      idle();
      wait_done();
      chk("post_reset_nwrites", wl_addr.size() - base, 32'd1);
      chk_write(base, 32'h0, 32'hDEAD_BEEF);

      step();
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
